// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / scoreboard slice.
`ifndef REGFILE_PKG_MACROS
`define REGFILE_PKG_MACROS
// Port idx of a flattened per-port vector whose fields are w bits wide.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package regfile_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back facing bus of the register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_clr;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     issue_ready;
  logic                     sb_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_clr, issue_valid, issue_addr,
    input  rd_data, rd_busy, issue_ready, sb_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_clr, issue_valid, issue_addr,
    output rd_data, rd_busy, issue_ready, sb_err
  );
endinterface

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register: +inc, -dec per cycle,
// clamps at 0 and flags underflow when more clears arrive than pending entries.
module sb_counter #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);
  localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
  localparam logic [SUM_W-1:0] MAX = SUM_W'({CNT_W{1'b1}});

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] dec_x;
  logic [SUM_W-1:0] diff;
  logic [CNT_W-1:0] nxt;

  // Next count with clamp at zero and saturation at max.
  always_comb begin
    sum       = SUM_W'(cnt) + SUM_W'(inc);
    dec_x     = SUM_W'(dec);
    diff      = sum - dec_x;
    underflow = dec_x > sum;
    if (underflow) begin
      nxt = '0;
    end else if (diff > MAX) begin
      nxt = '1;
    end else begin
      nxt = diff[CNT_W-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-back scoreboard: combinational reads
// with same-cycle bypass, prioritised writes, per-register pending counters.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned DEC_W = $clog2(NUM_WR + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]              mem [DEPTH];
  logic [DEPTH-1:0][CNT_W-1:0]    cnt;
  logic [DEPTH-1:1][DEC_W-1:0]    dec;
  logic [DEPTH-1:1]               inc;
  logic [DEPTH-1:1]               underflow;
  logic                           issue_ready_c;
  logic                           sb_err_q;
  logic [NUM_RD*DATA_W-1:0]       rd_data_c;
  logic [NUM_RD-1:0]              rd_busy_c;

  // Number of write-back ports retiring an entry of register a this cycle.
  function automatic logic [DEC_W-1:0] clears_to(
    input logic [NUM_WR-1:0]        clr,
    input logic [NUM_WR*ADDR_W-1:0] addrs,
    input logic [ADDR_W-1:0]        a
  );
    logic [DEC_W-1:0] n;
    n = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (clr[p] && (`RF_SLICE(addrs, p, ADDR_W) == a)) begin
        n = n + DEC_W'(1);
      end
    end
    return n;
  endfunction

  // Issue is refused only when the destination counter is full and nothing retires it now.
  always_comb begin
    issue_ready_c = 1'b1;
    if (!rst && (bus.issue_addr != '0)) begin
      issue_ready_c = (cnt[bus.issue_addr] != CNT_MAX) ||
                      (clears_to(bus.wr_clr, bus.wr_addr, bus.issue_addr) != '0);
    end
  end

  // Per-register increment/decrement requests for the counters.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < DEPTH; r++) begin
      inc[r] = bus.issue_valid && issue_ready_c && (bus.issue_addr == ADDR_W'(r));
      dec[r] = clears_to(bus.wr_clr, bus.wr_addr, ADDR_W'(r));
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .cnt       (cnt[r]),
      .underflow (underflow[r])
    );
  end

  // Array write; ascending port order lets the highest enabled port win an address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (bus.wr_en[p] && (`RF_SLICE(bus.wr_addr, p, ADDR_W) != '0)) begin
          mem[`RF_SLICE(bus.wr_addr, p, ADDR_W)] <= `RF_SLICE(bus.wr_data, p, DATA_W);
        end
      end
    end
  end

  // Read ports: array value overridden by the highest-index matching write (bypass).
  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a = `RF_SLICE(bus.rd_addr, i, ADDR_W);
      `RF_SLICE(rd_data_c, i, DATA_W) = DATA_W'(ZERO_WORD);
      if (!rst && bus.rd_en[i] && (a != '0)) begin
        `RF_SLICE(rd_data_c, i, DATA_W) = mem[a];
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (bus.wr_en[p] && (`RF_SLICE(bus.wr_addr, p, ADDR_W) == a)) begin
            `RF_SLICE(rd_data_c, i, DATA_W) = `RF_SLICE(bus.wr_data, p, DATA_W);
          end
        end
        rd_busy_c[i] = 32'(cnt[a]) > 32'(clears_to(bus.wr_clr, bus.wr_addr, a));
      end
    end
  end

  // Sticky scoreboard error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|underflow) begin
      sb_err_q <= 1'b1;
    end
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.rd_busy     = rd_busy_c;
  assign bus.issue_ready = issue_ready_c;
  assign bus.sb_err      = sb_err_q && !rst;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with integrated write-back scoreboard for the pipelined CPU core. It serves a configurable number of combinational read ports and prioritised write-back ports, with same-cycle write-to-read bypass. It also keeps a saturating pending-write counter per register, so decode can detect RAW hazards on in-flight results and stall. It sits between decode (read/issue) and write-back (write/clear).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, read port count
- NUM_WR, 2, write port count; higher index has priority
- CNT_W, 2, pending counter width; max outstanding = 2**CNT_W-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  flattened read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  flattened read data
- rd_busy  out  NUM_RD  register still has pending writes after this cycle's clears
- wr_en  in  NUM_WR  write enable per port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_clr  in  NUM_WR  this write retires one pending entry; valid without wr_en (retire without write)
- issue_valid  in  1  decode issues an instruction writing issue_addr
- issue_addr  in  ADDR_W  destination of issued instruction
- issue_ready  out  1  issue accepted this cycle
- sb_err  out  1  sticky: clear seen on a zero counter

## Operation
- Register 0: reads return 0, never busy, writes/clears/issues to it ignored, issue_ready=1 for it.
- Read port i: rd_en=0 or rst -> rd_data=0, rd_busy=0. Otherwise data = highest-index write port with wr_en && wr_addr==rd_addr (bypass), else array contents.
- Write: on posedge, each address is written by the highest-index enabled port targeting it; lower-priority same-address writes are dropped.
- Scoreboard counter per register: next = cnt + inc - dec.
  - inc = issue_valid && issue_ready && issue_addr==r.
  - dec = number of ports with wr_clr && wr_addr==r; range 0..NUM_WR.
- Underflow: dec > cnt+inc -> counter clamps to 0 and sb_err sets. sb_err is cleared only by rst.
- issue_ready = (issue_addr==0) || cnt[issue_addr] != max || any clear targets issue_addr this cycle.
- rd_busy = (cnt[rd_addr] - dec[rd_addr]) != 0, saturating at 0. Issue in the same cycle does not affect rd_busy.

## Timing
- Reads, rd_busy and issue_ready are combinational from inputs and current state; there is no registered output latency.
- Writes reach the array at the next posedge and are visible through the bypass in the same cycle.
- Counter updates take effect at the next posedge.
- Reset (any cycle, including mid-burst): all registers, counters and sb_err go to 0 at the posedge. While rst is high, rd_data=0, rd_busy=0, issue_ready=1, sb_err=0, and writes/issues are ignored.
- Simultaneous issue and clear on the same register with cnt=max: accepted, and the counter stays at max.

## Structure
- Shared package regfile_pkg holds the ZERO_WORD constant, default DATA_W/ADDR_W, and the flattened-slice helper macros.
- Sub-module sb_counter: one saturating up/down counter per register, with inputs inc, dec[count], outputs cnt and underflow. It is instantiated DEPTH-1 times via generate (register 0 has none).
- The priority write mux and the bypass network are implemented inline.

## Test plan
- Reset then read: write x5=0xDEADBEEF, assert rst for 1 cycle, read x5 -> 0, rd_busy=0, sb_err=0.
- Bypass + priority: same cycle, port0 writes x3=0x11 and port1 writes x3=0x22, read x3 -> 0x22 that cycle; next cycle array x3=0x22.
- Register 0: write x0=0xFFFFFFFF and issue x0 -> read 0, rd_busy=0, issue_ready=1, no counter change.
- Scoreboard: with CNT_W=2, issue x7 three times -> rd_busy=1 and issue_ready=0. A clear plus write x7=0x55 together with an issue to x7 -> accepted, count stays 3. Three more clears -> rd_busy drops in the cycle of the last clear, with data 0x55 via bypass.
- Underflow: clear x9 with counter 0 -> counter stays 0, sb_err=1 and held until rst.
- Dual clear: count x4=2, both ports clear x4 in one cycle -> rd_busy=0 that cycle, count 0 next, sb_err unchanged.
